// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax output datapath: element format and sizing helpers.
package softmax_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAC_W    = 8;
  localparam int unsigned DEFAULT_N = 64;

  // Signed Q8.8 probability element
  typedef logic signed [DATA_W-1:0] elem_t;

  // Index width for an n-element vector, never narrower than one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/softmax_prob_streamer_if.sv
// Element-serial valid/ready stream carrying one probability element and its index per beat.
interface softmax_prob_streamer_if #(
  parameter int unsigned N      = softmax_pkg::DEFAULT_N,
  parameter int unsigned DATA_W = softmax_pkg::DATA_W
);

  localparam int unsigned IDX_W = softmax_pkg::idx_w(N);

  logic [DATA_W-1:0] m_data;
  logic [IDX_W-1:0]  m_index;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;

  modport master (
    output m_data,
    output m_index,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_index,
    input  m_valid,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/prob_vec_fifo.sv
// Two-entry FIFO of whole probability vectors; a push into a full FIFO is legal only alongside a pop.
module prob_vec_fifo #(
  parameter int unsigned N      = softmax_pkg::DEFAULT_N,
  parameter int unsigned DATA_W = softmax_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [N*DATA_W-1:0]   din,
  output logic                  full,
  output logic                  empty,
  output logic [N*DATA_W-1:0]   head
);

  import softmax_pkg::*;

  localparam int unsigned VEC_W = N * DATA_W;

  logic [VEC_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage; when full, a same-cycle push lands in the slot being popped
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/softmax_prob_streamer.sv
// Buffers softmax probability vectors, replays them one element per beat and reports each vector's argmax.
module softmax_prob_streamer #(
  parameter int unsigned N      = softmax_pkg::DEFAULT_N,
  parameter int unsigned DATA_W = softmax_pkg::DATA_W,
  parameter int unsigned IDX_W  = softmax_pkg::idx_w(N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      valid_in,
  input  logic [N*DATA_W-1:0]       prob_flat,
  softmax_prob_streamer_if.master   m,
  output logic [IDX_W-1:0]          argmax_idx,
  output logic                      argmax_valid,
  output logic                      overflow
);

  import softmax_pkg::*;

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);

  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     drop;
  logic                     beat_valid;
  logic                     hs;
  logic                     last_hs;
  logic                     take;
  logic [N*DATA_W-1:0]      head;
  logic [IDX_W-1:0]         k;
  logic [IDX_W-1:0]         run_idx;
  logic signed [DATA_W-1:0] cur;
  logic signed [DATA_W-1:0] run_max;

  prob_vec_fifo #(
    .N      (N),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (prob_flat),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Beat handshake, FIFO control and drop detection
  assign beat_valid = ~empty & en;
  assign hs         = beat_valid & m.m_ready;
  assign last_hs    = hs & (k == K_LAST);
  assign pop        = last_hs;
  assign push       = en & valid_in & (~full | pop);
  assign drop       = en & valid_in & full & ~pop;

  // Head element select and running-max candidate
  assign cur  = head[DATA_W*k +: DATA_W];
  assign take = (k == '0) || (cur > run_max);

  // Stream outputs are driven from registered state; data reads zero when nothing is buffered
  assign m.m_valid = beat_valid;
  assign m.m_last  = beat_valid & (k == K_LAST);
  assign m.m_index = k;
  assign m.m_data  = empty ? '0 : cur;

  // Beat counter, argmax tracker and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k            <= '0;
      run_max      <= '0;
      run_idx      <= '0;
      argmax_idx   <= '0;
      argmax_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      argmax_valid <= last_hs;
      if (drop) overflow <= 1'b1;
      if (hs) begin
        k <= last_hs ? '0 : k + IDX_W'(1);
        if (take) begin
          run_max <= cur;
          run_idx <= k;
        end
      end
      if (last_hs) argmax_idx <= take ? k : run_idx;
    end
  end

endmodule

// File: tb/tb_softmax_prob_streamer.sv
// Scoreboard bench for softmax_prob_streamer: directed vectors, decoupled stream/argmax monitor.
`timescale 1ns/1ps
module tb_softmax_prob_streamer;

  localparam int unsigned N  = 64;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 6;

  typedef logic [N*DW-1:0] vec_t;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          valid_in;
  vec_t          prob_flat;
  logic [IW-1:0] argmax_idx;
  logic          argmax_valid;
  logic          overflow;

  softmax_prob_streamer_if #(.N(N), .DATA_W(DW)) sif ();

  softmax_prob_streamer #(.N(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .valid_in     (valid_in),
    .prob_flat    (prob_flat),
    .m            (sif),
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  beat_t beat_q[$];
  int    am_q[$];
  int    beats_seen = 0;
  int    ready_mode = 0;
  int    cyc_n = 0;
  logic  exp_av = 1'b0;
  beat_t mon_e;
  bit    mon_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event not expected or bound expired at %0t", name, $time);
  endtask

  function automatic vec_t mk_ramp();
    vec_t v = '0;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = 16'(4 * k);
    return v;
  endfunction

  function automatic vec_t mk_desc();
    vec_t v = '0;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = 16'(512 - 4 * k);
    return v;
  endfunction

  function automatic vec_t mk_const(input logic [DW-1:0] c);
    vec_t v = '0;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = c;
    return v;
  endfunction

  function automatic vec_t mk_spike();
    vec_t v = '0;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = (k == 17) ? 16'h0B26 : 16'hF5BE;
    return v;
  endfunction

  task automatic expect_vec(input vec_t v, input int am);
    beat_t b;
    for (int k = 0; k < N; k++) begin
      b.data = v[k*DW +: DW];
      b.idx  = IW'(k);
      b.last = (k == N - 1);
      beat_q.push_back(b);
    end
    am_q.push_back(am);
  endtask

  // One-cycle valid_in strobe; scoreboard entry added after the capture edge
  task automatic push_cycle(input vec_t v, input bit acc, input int am);
    valid_in  = 1'b1;
    prob_flat = v;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    if (acc) expect_vec(v, am);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((beat_q.size() != 0 || am_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) begin
      fail(name);
      beat_q.delete();
      am_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Downstream ready: always high, or the pattern 1,0,0 repeating
  initial begin
    sif.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc_n++;
      sif.m_ready = (ready_mode == 0) ? 1'b1 : (cyc_n % 3 == 0);
    end
  end

  // Monitor: pops expected beats on handshakes, checks holds, gaps and argmax pulses
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_av = 1'b0;
      end else begin
        mon_last = 1'b0;
        if (en && beat_q.size() > 0) check("stream_gap", 64'(sif.m_valid), 64'd1);
        if (sif.m_valid && sif.m_ready) begin
          if (beat_q.size() == 0) fail("unexpected_beat");
          else begin
            mon_e = beat_q.pop_front();
            beats_seen++;
            check("beat", 64'({sif.m_data, sif.m_index, sif.m_last}), 64'(mon_e));
            mon_last = mon_e.last;
          end
        end else if (sif.m_valid && beat_q.size() > 0) begin
          mon_e = beat_q[0];
          check("stall_hold", 64'({sif.m_data, sif.m_index, sif.m_last}), 64'(mon_e));
        end
        check("argmax_valid", 64'(argmax_valid), 64'(exp_av));
        if (argmax_valid) begin
          if (am_q.size() == 0) fail("unexpected_argmax");
          else check("argmax_idx", 64'(argmax_idx), 64'(am_q.pop_front()));
        end
        exp_av = mon_last;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int b0;
    rst       = 1'b1;
    en        = 1'b1;
    valid_in  = 1'b0;
    prob_flat = '0;
    repeat (2) @(negedge clk);
    check("rst_m_valid", 64'(sif.m_valid), 64'd0);
    check("rst_m_last", 64'(sif.m_last), 64'd0);
    check("rst_m_data", 64'(sif.m_data), 64'd0);
    check("rst_m_index", 64'(sif.m_index), 64'd0);
    check("rst_argmax_valid", 64'(argmax_valid), 64'd0);
    check("rst_argmax_idx", 64'(argmax_idx), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Ramp, ties, negatives with a single positive spike
    push_cycle(mk_ramp(), 1'b1, 63);
    drain("drain_ramp");
    push_cycle(mk_const(16'h0100), 1'b1, 0);
    drain("drain_ties");
    push_cycle(mk_spike(), 1'b1, 17);
    drain("drain_spike");

    // Backpressure
    ready_mode = 1;
    b0 = beats_seen;
    push_cycle(mk_ramp(), 1'b1, 63);
    drain("drain_bp");
    check("bp_beat_count", 64'(beats_seen - b0), 64'd64);
    ready_mode = 0;
    @(posedge clk);
    #1;
    check("overflow_clear", 64'(overflow), 64'd0);

    // Push coinciding with the pop of a full buffer
    push_cycle(mk_ramp(), 1'b1, 63);
    push_cycle(mk_desc(), 1'b1, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sif.m_valid && sif.m_ready && sif.m_last) && n < 200);
    if (n >= 200) fail("wait_first_last");
    valid_in  = 1'b1;
    prob_flat = mk_spike();
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    expect_vec(mk_spike(), 17);
    @(negedge clk);
    check("overflow_pushpop", 64'(overflow), 64'd0);
    drain("drain_pushpop");

    // Burst of three: third is dropped
    push_cycle(mk_spike(), 1'b1, 17);
    push_cycle(mk_ramp(), 1'b1, 63);
    push_cycle(mk_const(16'h0100), 1'b0, 0);
    @(negedge clk);
    check("overflow_set", 64'(overflow), 64'd1);
    drain("drain_burst");
    check("overflow_sticky", 64'(overflow), 64'd1);

    // Asynchronous reset mid-vector
    push_cycle(mk_ramp(), 1'b1, 63);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sif.m_valid && sif.m_index == IW'(30)) && n < 200);
    if (n >= 200) fail("wait_k30");
    #1;
    rst = 1'b1;
    beat_q.delete();
    am_q.delete();
    #1;
    check("arst_m_valid", 64'(sif.m_valid), 64'd0);
    check("arst_m_data", 64'(sif.m_data), 64'd0);
    check("arst_m_index", 64'(sif.m_index), 64'd0);
    check("arst_m_last", 64'(sif.m_last), 64'd0);
    check("arst_overflow", 64'(overflow), 64'd0);
    check("arst_argmax_idx", 64'(argmax_idx), 64'd0);
    check("arst_argmax_valid", 64'(argmax_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_reset", 64'(sif.m_valid), 64'd0);
    end

    // Disabled block ignores valid_in
    @(posedge clk);
    #1;
    en = 1'b0;
    push_cycle(mk_ramp(), 1'b0, 0);
    en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_capture_disabled", 64'(sif.m_valid), 64'd0);
    end
    check("no_overflow_disabled", 64'(overflow), 64'd0);

    // Freeze mid-stream, then resume
    @(posedge clk);
    #1;
    push_cycle(mk_ramp(), 1'b1, 63);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sif.m_valid && sif.m_index == IW'(10)) && n < 200);
    if (n >= 200) fail("wait_k10");
    @(posedge clk);
    #1;
    en = 1'b0;
    @(negedge clk);
    check("frozen_valid", 64'(sif.m_valid), 64'd0);
    check("frozen_index", 64'(sif.m_index), 64'd11);
    push_cycle(mk_desc(), 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    drain("drain_freeze");
    check("overflow_after_freeze", 64'(overflow), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
